// File: rtl/cal_fifo_pkg.sv
// Shared definitions for the calibrator average-data FIFO controller.
package cal_fifo_pkg;

   localparam int DWIDTH_DEF = 32;
   localparam int DEPTH_DEF  = 128;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

   localparam int ADDR_W_DEF = clog2(DEPTH_DEF);

   // Pointer with one extra wrap bit so full and empty are distinguishable.
   typedef logic [ADDR_W_DEF:0] ptr_t;

endpackage

// File: rtl/cal_fifo_ptr.sv
// One FIFO pointer: address bits plus a wrap bit, advancing by one when enabled.
module cal_fifo_ptr #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   output logic [ADDR_W:0]   ptr
);

   // Power-of-two depth lets the natural binary rollover toggle the wrap bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (en) begin
         ptr <= ptr + {{ADDR_W{1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/cal_average_fifo_ctrl.sv
// FIFO controller for the calibrator average-data RAM: pointers, flags, occupancy
// and a read-valid pipeline matched to the RAM's registered-address read path.
module cal_average_fifo_ctrl
   import cal_fifo_pkg::*;
#(
   parameter int DWIDTH    = DWIDTH_DEF,
   parameter int DEPTH     = DEPTH_DEF,
   parameter int ADDR_W    = clog2(DEPTH),
   parameter int RD_LAT    = 2,
   parameter int AFULL_TH  = 120,
   parameter int AEMPTY_TH = 8
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              WE,
   input  logic [DWIDTH-1:0] DIN,
   input  logic              RE,
   output logic [DWIDTH-1:0] DOUT,
   output logic              DVLD,
   output logic              FULL,
   output logic              EMPTY,
   output logic              ALMOST_FULL,
   output logic              ALMOST_EMPTY,
   output logic [ADDR_W:0]   COUNT,
   output logic              OVERFLOW,
   output logic              UNDERFLOW,
   output logic [ADDR_W-1:0] RAM_WADDR,
   output logic [DWIDTH-1:0] RAM_WDATA,
   output logic              RAM_WEN,
   output logic [ADDR_W-1:0] RAM_RADDR,
   output logic              RAM_REN,
   input  logic [DWIDTH-1:0] RAM_RDATA
);

   localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W + 1)'(AFULL_TH);
   localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W + 1)'(AEMPTY_TH);

   logic [ADDR_W:0]   wr_ptr;
   logic [ADDR_W:0]   rd_ptr;
   logic              wr_ok;
   logic              rd_ok;
   logic              ptr_full;
   logic              ptr_empty;
   logic [ADDR_W:0]   count_q;
   logic [ADDR_W:0]   count_nxt;
   logic              afull_q;
   logic              aempty_q;
   logic              ovf_q;
   logic              unf_q;
   logic [RD_LAT-1:0] vld_pipe;

   // WE and RE are single-cycle request strobes with no back-pressure: a
   // request is accepted in the cycle it is high unless FULL (write) or EMPTY
   // (read) is set; a rejected request is dropped and flagged one cycle later
   // on OVERFLOW/UNDERFLOW. Accepted reads return DOUT with DVLD RD_LAT later.
   always_comb begin
      ptr_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
      ptr_empty = (wr_ptr == rd_ptr);
      wr_ok     = WE & ~ptr_full;
      rd_ok     = RE & ~ptr_empty;
      count_nxt = count_q + {{ADDR_W{1'b0}}, wr_ok} - {{ADDR_W{1'b0}}, rd_ok};
   end

   cal_fifo_ptr #(
      .ADDR_W (ADDR_W)
   ) u_wr_ptr (
      .clk (CLOCK),
      .rst (RESET),
      .en  (wr_ok),
      .ptr (wr_ptr)
   );

   cal_fifo_ptr #(
      .ADDR_W (ADDR_W)
   ) u_rd_ptr (
      .clk (CLOCK),
      .rst (RESET),
      .en  (rd_ok),
      .ptr (rd_ptr)
   );

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         count_q  <= '0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         count_q  <= count_nxt;
         afull_q  <= (count_nxt >= AFULL_C);
         aempty_q <= (count_nxt <= AEMPTY_C);
         ovf_q    <= WE & ptr_full;
         unf_q    <= RE & ptr_empty;
      end
   end

   // Valid tracks the RAM's address register plus output pipe stage; reset
   // clears it so reads in flight at reset never surface.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= rd_ok;
         for (int i = 1; i < RD_LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   always_comb begin
      RAM_WEN      = wr_ok;
      RAM_WADDR    = wr_ptr[ADDR_W-1:0];
      RAM_WDATA    = DIN;
      RAM_REN      = rd_ok;
      RAM_RADDR    = rd_ptr[ADDR_W-1:0];
      DOUT         = RAM_RDATA;
      DVLD         = vld_pipe[RD_LAT-1];
      FULL         = ptr_full;
      EMPTY        = ptr_empty;
      COUNT        = count_q;
      ALMOST_FULL  = afull_q;
      ALMOST_EMPTY = aempty_q;
      OVERFLOW     = ovf_q;
      UNDERFLOW    = unf_q;
   end

endmodule
